// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - shared types, default geometry and gradient widths for the Sobel engine
package sobel_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        READ   = 2'b01,
        FLUSH  = 2'b10,
        DONE_S = 2'b11
    } state_t;

    localparam int IMG_W_DEF = 320;
    localparam int IMG_H_DEF = 240;
    localparam int GRAD_W    = 11;
    localparam int MAG_W     = 12;

    // |g| never exceeds 1020, so the negation cannot overflow GRAD_W bits
    function automatic logic [MAG_W-1:0] abs_grad(input logic signed [GRAD_W-1:0] g);
        logic [GRAD_W-1:0] a;
        a = g[GRAD_W-1] ? -g : g;
        return {1'b0, a};
    endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// rtl/sobel_line_buffer.sv - circular two-row delay providing the row-above and row-two-above taps
module sobel_line_buffer #(
    parameter int IMG_W = 320,
    parameter int PIX_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [PIX_W-1:0] din,
    output logic [PIX_W-1:0] tap1,
    output logic [PIX_W-1:0] tap2
);

    localparam int PTR_W = $clog2(IMG_W);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(IMG_W - 1);

    logic [PIX_W-1:0] row1_mem [IMG_W];
    logic [PIX_W-1:0] row2_mem [IMG_W];
    logic [PTR_W-1:0] ptr_q, ptr_d;

    assign tap1 = row1_mem[ptr_q];
    assign tap2 = row2_mem[ptr_q];

    always_comb begin
        ptr_d = ptr_q;
        if (clr) begin
            ptr_d = '0;
        end else if (en) begin
            ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Storage is never cleared: every entry is rewritten before a non-border window reads it
    always_ff @(posedge clk) begin
        if (en) begin
            row1_mem[ptr_q] <= din;
            row2_mem[ptr_q] <= row1_mem[ptr_q];
        end
    end

endmodule

// File: rtl/sobel_edge_engine.sv
// rtl/sobel_edge_engine.sv - raster-scan 3x3 Sobel magnitude from gray BRAM into edge BRAM
module sobel_edge_engine
    import sobel_pkg::*;
#(
    parameter int IMG_W  = IMG_W_DEF,
    parameter int IMG_H  = IMG_H_DEF,
    parameter int ADDR_W = 17,
    parameter int PIX_W  = 8
) (
    input  logic              i_CLK,
    input  logic              i_RSTn,
    input  logic              START,
    input  logic              THRESH_EN,
    input  logic [MAG_W-1:0]  THRESH,
    output logic              GRAY_RD_EN,
    output logic [ADDR_W-1:0] GRAY_RD_ADDR,
    input  logic [PIX_W-1:0]  GRAY_RD_DATA,
    output logic              EDGE_WR_EN,
    output logic [ADDR_W-1:0] EDGE_WR_ADDR,
    output logic [PIX_W-1:0]  EDGE_WR_DATA,
    output logic              BUSY,
    output logic              DONE,
    output logic [1:0]        ON_STATE
);

    localparam int N     = IMG_W * IMG_H;
    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H + 2);
    localparam int FL_W  = $clog2(IMG_W + 2);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(IMG_H - 1);
    localparam logic [FL_W-1:0]   FL_LAST   = FL_W'(IMG_W + 1);
    localparam logic [MAG_W-1:0]  PIX_MAX   = MAG_W'((1 << PIX_W) - 1);

    function automatic logic signed [GRAD_W-1:0] wsum(input logic [PIX_W-1:0] a, b, c);
        return $signed(GRAD_W'(a) + (GRAD_W'(b) << 1) + GRAD_W'(c));
    endfunction

    state_t              state_q, state_d;
    logic                busy_q, busy_d, done_q, done_d;
    logic                rd_en_q, rd_en_d, vrd_q, vrd_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [FL_W-1:0]     fl_cnt_q, fl_cnt_d;
    logic                thr_en_q, thr_en_d;
    logic [MAG_W-1:0]    thr_q, thr_d;
    logic                s1_vld_q, s1_vld_d, s1_real_q, s1_real_d;
    logic [COL_W-1:0]    kcol_q, kcol_d;
    logic [ROW_W-1:0]    krow_q, krow_d;
    logic [PIX_W-1:0]    win_q [3][3];
    logic [PIX_W-1:0]    win_d [3][3];
    logic                win_vld_q, win_vld_d, win_border_q, win_border_d;
    logic signed [GRAD_W-1:0] gx_q, gx_d, gy_q, gy_d;
    logic                g_vld_q, g_vld_d, g_border_q, g_border_d;
    logic [ADDR_W-1:0]   wr_cnt_q, wr_cnt_d;
    logic                edge_en_q, edge_en_d;
    logic [ADDR_W-1:0]   edge_addr_q, edge_addr_d;
    logic [PIX_W-1:0]    edge_data_q, edge_data_d;

    logic                start_go, shift;
    logic [PIX_W-1:0]    pix_in, tap1, tap2;
    logic [COL_W-1:0]    ccol;
    logic [ROW_W-1:0]    crow;
    logic                pos_ok;
    logic [MAG_W-1:0]    mag;

    assign start_go = (state_q == IDLE) && START;
    assign shift    = s1_vld_q;
    assign pix_in   = s1_real_q ? GRAY_RD_DATA : '0;

    sobel_line_buffer #(.IMG_W(IMG_W), .PIX_W(PIX_W)) u_line_buffer (
        .clk   (i_CLK),
        .rst_n (i_RSTn),
        .clr   (start_go),
        .en    (shift),
        .din   (pix_in),
        .tap1  (tap1),
        .tap2  (tap2)
    );

    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        rd_en_d   = rd_en_q;
        rd_addr_d = rd_addr_q;
        vrd_d     = vrd_q;
        fl_cnt_d  = fl_cnt_q;
        thr_en_d  = thr_en_q;
        thr_d     = thr_q;
        case (state_q)
            IDLE: begin
                if (START) begin
                    state_d   = READ;
                    busy_d    = 1'b1;
                    rd_en_d   = 1'b1;
                    rd_addr_d = '0;
                    thr_en_d  = THRESH_EN;
                    thr_d     = THRESH;
                end
            end
            READ: begin
                if (rd_addr_q == LAST_ADDR) begin
                    rd_en_d   = 1'b0;
                    rd_addr_d = '0;
                    vrd_d     = 1'b1;
                    fl_cnt_d  = FL_W'(1);
                    state_d   = FLUSH;
                end else begin
                    rd_addr_d = rd_addr_q + ADDR_W'(1);
                end
            end
            FLUSH: begin
                if (vrd_q) begin
                    if (fl_cnt_q == FL_LAST) vrd_d = 1'b0;
                    else                     fl_cnt_d = fl_cnt_q + FL_W'(1);
                end
                if (edge_en_q && edge_addr_q == LAST_ADDR) begin
                    state_d = DONE_S;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            DONE_S:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Centre of the window after shifting pixel k sits one row and one column behind k
    always_comb begin
        ccol   = (kcol_q == '0) ? COL_LAST : kcol_q - COL_W'(1);
        crow   = (kcol_q == '0) ? krow_q - ROW_W'(2) : krow_q - ROW_W'(1);
        pos_ok = (krow_q >= ROW_W'(2)) || (krow_q == ROW_W'(1) && kcol_q != '0);
    end

    always_comb begin
        s1_vld_d     = rd_en_q | vrd_q;
        s1_real_d    = rd_en_q;
        kcol_d       = kcol_q;
        krow_d       = krow_q;
        win_d        = win_q;
        win_vld_d    = 1'b0;
        win_border_d = win_border_q;
        if (start_go) begin
            kcol_d = '0;
            krow_d = '0;
        end else if (shift) begin
            if (kcol_q == COL_LAST) begin
                kcol_d = '0;
                krow_d = krow_q + ROW_W'(1);
            end else begin
                kcol_d = kcol_q + COL_W'(1);
            end
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2]  = tap2;
            win_d[1][2]  = tap1;
            win_d[2][2]  = pix_in;
            win_vld_d    = pos_ok;
            win_border_d = (ccol == '0) || (ccol == COL_LAST) || (crow == '0) || (crow == ROW_LAST);
        end
    end

    always_comb begin
        g_vld_d    = win_vld_q;
        g_border_d = win_border_q;
        gx_d = wsum(win_q[0][2], win_q[1][2], win_q[2][2]) - wsum(win_q[0][0], win_q[1][0], win_q[2][0]);
        gy_d = wsum(win_q[2][0], win_q[2][1], win_q[2][2]) - wsum(win_q[0][0], win_q[0][1], win_q[0][2]);

        mag         = abs_grad(gx_q) + abs_grad(gy_q);
        edge_en_d   = g_vld_q;
        edge_addr_d = edge_addr_q;
        edge_data_d = edge_data_q;
        wr_cnt_d    = wr_cnt_q;
        if (start_go) begin
            wr_cnt_d = '0;
        end else if (g_vld_q) begin
            edge_addr_d = wr_cnt_q;
            wr_cnt_d    = wr_cnt_q + ADDR_W'(1);
            if (g_border_q)    edge_data_d = '0;
            else if (thr_en_q) edge_data_d = (mag >= thr_q) ? '1 : '0;
            else               edge_data_d = (mag > PIX_MAX) ? '1 : mag[PIX_W-1:0];
        end
    end

    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            rd_en_q      <= 1'b0;
            rd_addr_q    <= '0;
            vrd_q        <= 1'b0;
            fl_cnt_q     <= '0;
            thr_en_q     <= 1'b0;
            thr_q        <= '0;
            s1_vld_q     <= 1'b0;
            s1_real_q    <= 1'b0;
            kcol_q       <= '0;
            krow_q       <= '0;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    win_q[r][c] <= '0;
            win_vld_q    <= 1'b0;
            win_border_q <= 1'b0;
            gx_q         <= '0;
            gy_q         <= '0;
            g_vld_q      <= 1'b0;
            g_border_q   <= 1'b0;
            wr_cnt_q     <= '0;
            edge_en_q    <= 1'b0;
            edge_addr_q  <= '0;
            edge_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            rd_en_q      <= rd_en_d;
            rd_addr_q    <= rd_addr_d;
            vrd_q        <= vrd_d;
            fl_cnt_q     <= fl_cnt_d;
            thr_en_q     <= thr_en_d;
            thr_q        <= thr_d;
            s1_vld_q     <= s1_vld_d;
            s1_real_q    <= s1_real_d;
            kcol_q       <= kcol_d;
            krow_q       <= krow_d;
            win_q        <= win_d;
            win_vld_q    <= win_vld_d;
            win_border_q <= win_border_d;
            gx_q         <= gx_d;
            gy_q         <= gy_d;
            g_vld_q      <= g_vld_d;
            g_border_q   <= g_border_d;
            wr_cnt_q     <= wr_cnt_d;
            edge_en_q    <= edge_en_d;
            edge_addr_q  <= edge_addr_d;
            edge_data_q  <= edge_data_d;
        end
    end

    assign GRAY_RD_EN   = rd_en_q;
    assign GRAY_RD_ADDR = rd_addr_q;
    assign EDGE_WR_EN   = edge_en_q;
    assign EDGE_WR_ADDR = edge_addr_q;
    assign EDGE_WR_DATA = edge_data_q;
    assign BUSY         = busy_q;
    assign DONE         = done_q;
    assign ON_STATE     = state_q;

endmodule

// File: doc/sobel_edge_engine.md
Name: sobel_edge_engine

Overview:
- Downstream neighbour of the RGB-to-gray stage. After the gray BRAM is fully written, this block reads the 8-bit gray image in raster order.
- It computes a 3x3 Sobel gradient magnitude per pixel and writes an 8-bit edge image into an edge BRAM, one result per clock.
- Control and status are exposed to the processor through AXI slave registers.

Parameters:
- IMG_W, 320, image width in pixels
- IMG_H, 240, image height in pixels
- ADDR_W, 17, BRAM address width (IMG_W*IMG_H <= 2**ADDR_W)
- PIX_W, 8, gray/edge pixel width

Ports:
- i_CLK  in  1  system clock, all logic on rising edge
- i_RSTn  in  1  asynchronous active-low reset
- START  in  1  single-cycle start pulse (gray BRAM write done)
- THRESH_EN  in  1  1 = binary output mode
- THRESH  in  12  magnitude threshold, sampled at START
- GRAY_RD_EN  out  1  gray BRAM read enable
- GRAY_RD_ADDR  out  ADDR_W  gray BRAM read address
- GRAY_RD_DATA  in  PIX_W  gray BRAM data; valid exactly 1 cycle after GRAY_RD_EN
- EDGE_WR_EN  out  1  edge BRAM write enable
- EDGE_WR_ADDR  out  ADDR_W  edge BRAM write address
- EDGE_WR_DATA  out  PIX_W  edge pixel
- BUSY  out  1  high from the cycle after START until DONE
- DONE  out  1  one-cycle pulse after the last write
- ON_STATE  out  2  00 IDLE, 01 READ, 10 FLUSH, 11 DONE

Behaviour:
- Reset: all outputs 0, FSM to IDLE, counters 0. Line-buffer contents are not cleared; every entry is rewritten before it is used.
- Reset mid-operation aborts immediately. There are no further reads or writes; the next START restarts from pixel 0.

FSM:
- IDLE: on START, latch THRESH_EN/THRESH, go to READ.
- READ: one read per cycle, k = 0..N-1 (N = IMG_W*IMG_H). After k = N-1 go to FLUSH.
- FLUSH: IMG_W+1 virtual reads with GRAY_RD_EN = 0. The shift logic inserts 0 as data. Then wait for the pipeline to drain.
- DONE: single cycle. DONE = 1, BUSY = 0. Go to IDLE.
- START is ignored outside IDLE.

Window:
- Two line buffers, each IMG_W x PIX_W, plus a 3x3 shift-register window fed with each returned pixel.
- Center index j = k - IMG_W - 1. A result for j is produced once j >= 0, giving exactly N writes.
- Write order is j = 0..N-1. EDGE_WR_ADDR = j, with no gaps or repeats.

Latency:
- EDGE_WR_EN for center j asserts exactly 4 cycles after the (real or virtual) read cycle of k = j+IMG_W+1.
- Stages: data return, window update, Gx/Gy register, magnitude register/write.

Arithmetic (p[r][c], row 0 = top):
- Gx = (p02 + 2p12 + p22) - (p00 + 2p10 + p20), 11-bit signed.
- Gy = (p20 + 2p21 + p22) - (p00 + 2p01 + p02), 11-bit signed.
- mag = |Gx| + |Gy|, 12-bit unsigned, max 2040.
- THRESH_EN = 0: out = min(mag, 255).
- THRESH_EN = 1: out = (mag >= THRESH) ? 255 : 0.

Border:
- Center on row 0, row IMG_H-1, col 0 or col IMG_W-1: out = 0 and the write still occurs. This hides row-wrap windows.

Decomposition:
- Package sobel_pkg:
  - state_t enum (IDLE, READ, FLUSH, DONE_S) with 2-bit encoding matching ON_STATE.
  - Default IMG_W/IMG_H.
  - Derived widths: GRAD_W = 11, MAG_W = 12.
- Sub-module sobel_line_buffer:
  - Circular two-row delay of IMG_W entries.
  - Single column pointer wrapping at IMG_W-1.
  - Outputs the row-above and row-two-above taps.

Test Plan (IMG_W=8, IMG_H=6 unless stated; bench models a 1-cycle-latency BRAM):
- Constant image 0x80, THRESH_EN=0 -> 48 writes, addresses 0..47 in order, all data 0; DONE one cycle after the write to 47; BUSY falls with DONE.
- Vertical step, cols 0-3 = 0, cols 4-7 = 255 -> interior (rows 1-4) cols 3 and 4 = 255 (Gx = 1020 saturated); all others 0.
- Horizontal ramp p = 10*c -> interior pixels = 80 (Gx = 80, Gy = 0); border pixels = 0.
- Same ramp, THRESH_EN=1: THRESH=81 -> all 0; THRESH=80 -> interior 255, border 0.
- Latency check: EDGE_WR_EN for j=0 asserts 4 cycles after the read of k=9. Total START-to-DONE cycles = 48 + 9 + 4 + 2 (must be constant).
- Robustness: START pulses while BUSY are ignored, giving exactly 48 writes. i_RSTn low at write 20 clears outputs at once; a new START yields a correct full image. Full-size 320x240 run gives 76800 writes.
